// File: rtl/clk_div_prog_if.sv
// Control and status bundle for clk_div_prog: run enable, divisor load handshake, divided outputs.
// Signal prefixes are from the divider's point of view (i_ = into the divider, o_ = out of it).
interface clk_div_prog_if #(
    parameter int CNT_W = 16
);
    logic             i_en;
    logic [CNT_W-1:0] i_div_in;
    logic             i_div_load;
    logic             o_div_ack;
    logic [CNT_W-1:0] o_cur_div;
    logic             o_clk_out;
    logic             o_tick;

    modport master (
        output i_en, i_div_in, i_div_load,
        input  o_div_ack, o_cur_div, o_clk_out, o_tick
    );

    modport slave (
        input  i_en, i_div_in, i_div_load,
        output o_div_ack, o_cur_div, o_clk_out, o_tick
    );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with a glitch-free divisor load handshake.
// Optional macro CLKDIV_DUTY50_EN: adds a negedge flop so odd divisors get a true 50% duty cycle.
module clk_div_prog #(
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 3
) (
    input logic           clk,
    input logic           reset,
    clk_div_prog_if.slave bus
);

    localparam logic [CNT_W-1:0] DIV_RST = (DIV_DEFAULT < 2) ? CNT_W'(2) : CNT_W'(DIV_DEFAULT);

    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
        return (d < CNT_W'(2)) ? CNT_W'(2) : d;
    endfunction

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cur_div;
    logic [CNT_W-1:0] r_pend_div;
    logic             r_pend_v;
    logic             r_clk_pos;
    logic             r_tick;
    logic             r_ack;

    logic             w_wrap;
    logic             w_apply;
    logic [CNT_W-1:0] w_div_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_low_len;

    // A pending divisor lands on the wrap edge while running, or on any idle edge.
    assign w_wrap     = (r_cnt == r_cur_div);
    assign w_apply    = r_pend_v && (!bus.i_en || w_wrap);
    assign w_div_next = w_apply ? r_pend_div : r_cur_div;
    assign w_cnt_next = w_wrap ? CNT_W'(1) : r_cnt + CNT_W'(1);
    assign w_low_len  = w_div_next - (w_div_next >> 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_cur_div  <= DIV_RST;
            r_pend_div <= DIV_RST;
            r_pend_v   <= 1'b0;
            r_clk_pos  <= 1'b0;
            r_tick     <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            r_ack <= w_apply;
            if (w_apply) begin
                r_cur_div <= r_pend_div;
                r_pend_v  <= 1'b0;
            end
            // NOTE: a load on the applying edge re-arms pending; the later non-blocking write wins.
            if (bus.i_div_load) begin
                r_pend_div <= clamp_div(bus.i_div_in);
                r_pend_v   <= 1'b1;
            end
            if (bus.i_en) begin
                r_cnt     <= w_cnt_next;
                r_clk_pos <= (w_cnt_next > w_low_len);
                r_tick    <= (w_cnt_next == w_low_len + CNT_W'(1));
            end else begin
                r_cnt     <= '0;
                r_clk_pos <= 1'b0;
                r_tick    <= 1'b0;
            end
        end
    end

`ifdef CLKDIV_DUTY50_EN
    logic r_clk_neg;

    // Half-cycle delayed copy stretches the high phase by 0.5 cycle for odd divisors.
    always_ff @(negedge clk) begin
        if (reset) r_clk_neg <= 1'b0;
        else       r_clk_neg <= r_clk_pos;
    end

    assign bus.o_clk_out = r_cur_div[0] ? (r_clk_pos | r_clk_neg) : r_clk_pos;
`else
    assign bus.o_clk_out = r_clk_pos;
`endif

    assign bus.o_tick    = r_tick;
    assign bus.o_div_ack = r_ack;
    assign bus.o_cur_div = r_cur_div;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: stimulus pushes hand-computed per-edge expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_clk_div_prog;

    typedef struct packed {
        logic        clk_o;
        logic        tick;
        logic        ack;
        logic [15:0] cur;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   edge_idx = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    clk_div_prog_if #(.CNT_W(16)) bus ();

    clk_div_prog #(.CNT_W(16), .DIV_DEFAULT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outputs are compared at negedge, well away from the updating posedge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            edge_idx++;
            check($sformatf("clk_out@%0d", edge_idx), 32'(bus.o_clk_out), 32'(e.clk_o));
            check($sformatf("tick@%0d", edge_idx),    32'(bus.o_tick),    32'(e.tick));
            check($sformatf("div_ack@%0d", edge_idx), 32'(bus.o_div_ack), 32'(e.ack));
            check($sformatf("cur_div@%0d", edge_idx), 32'(bus.o_cur_div), 32'(e.cur));
        end
    end

    task automatic step(input logic rst, input logic en, input logic ld, input logic [15:0] din,
                        input logic e_clk, input logic e_tick, input logic e_ack,
                        input logic [15:0] e_cur);
        exp_t e;
        reset          = rst;
        bus.i_en       = en;
        bus.i_div_load = ld;
        bus.i_div_in   = din;
        @(posedge clk);
        #1;
        e.clk_o = e_clk;
        e.tick  = e_tick;
        e.ack   = e_ack;
        e.cur   = e_cur;
        exp_q.push_back(e);
    endtask

    // Patterns read left-to-right in edge order.
    task automatic run(input int n, input logic [31:0] cpat, input logic [31:0] tpat,
                       input logic [15:0] cur);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b1, 1'b0, 16'd0, cpat[n-1-i], tpat[n-1-i], 1'b0, cur);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(1, 0, 0, 16'd0, 0, 0, 0, 16'd3);
        step(1, 0, 0, 16'd0, 0, 0, 0, 16'd3);
        // Default D=3: 0,0,1 repeating, tick on every 3rd edge
        run(9, 9'b001001001, 9'b001001001, 16'd3);
        // Load 4 mid-period: old period completes, ack on the wrap edge
        step(0, 1, 0, 16'd0, 0, 0, 0, 16'd3);
        step(0, 1, 1, 16'd4, 0, 0, 0, 16'd3);
        step(0, 1, 0, 16'd0, 1, 1, 0, 16'd3);
        step(0, 1, 0, 16'd0, 0, 0, 1, 16'd4);
        run(7, 7'b0110011, 7'b0100010, 16'd4);
        // Load 5 on the wrap edge, then 7: single ack at the following wrap, period 7
        step(0, 1, 1, 16'd5, 0, 0, 0, 16'd4);
        step(0, 1, 1, 16'd7, 0, 0, 0, 16'd4);
        step(0, 1, 0, 16'd0, 1, 1, 0, 16'd4);
        step(0, 1, 0, 16'd0, 1, 0, 0, 16'd4);
        step(0, 1, 0, 16'd0, 0, 0, 1, 16'd7);
        run(13, 13'b0001110000111, 13'b0001000000100, 16'd7);
        // Load 1 (clamped to 2) on a wrap edge: applied one full period later
        step(0, 1, 1, 16'd1, 0, 0, 0, 16'd7);
        run(6, 6'b000111, 6'b000100, 16'd7);
        step(0, 1, 0, 16'd0, 0, 0, 1, 16'd2);
        run(6, 6'b101010, 6'b101010, 16'd2);
        // Idle loads apply on the next edge; 0 clamps to 2
        step(0, 0, 1, 16'd9, 0, 0, 0, 16'd2);
        step(0, 0, 0, 16'd0, 0, 0, 1, 16'd9);
        step(0, 0, 1, 16'd0, 0, 0, 0, 16'd9);
        step(0, 0, 0, 16'd0, 0, 0, 1, 16'd2);
        run(4, 4'b0101, 4'b0101, 16'd2);
        // Back to D=3, then drop en while clk_out is high
        step(0, 1, 1, 16'd3, 0, 0, 0, 16'd2);
        step(0, 1, 0, 16'd0, 1, 1, 0, 16'd2);
        step(0, 1, 0, 16'd0, 0, 0, 1, 16'd3);
        step(0, 1, 0, 16'd0, 0, 0, 0, 16'd3);
        step(0, 1, 0, 16'd0, 1, 1, 0, 16'd3);
        step(0, 0, 0, 16'd0, 0, 0, 0, 16'd3);
        run(3, 3'b001, 3'b001, 16'd3);
        // Reset with a pending load: discarded, no ack even once idle
        step(0, 1, 1, 16'd8, 0, 0, 0, 16'd3);
        step(1, 1, 0, 16'd0, 0, 0, 0, 16'd3);
        step(0, 0, 0, 16'd0, 0, 0, 0, 16'd3);
        step(0, 0, 0, 16'd0, 0, 0, 0, 16'd3);

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
